// File: rtl/uart_rx_fifo.sv
// UART receiver: synchroniser, 3-sample majority vote, configurable frame
// format, per-word error flags and a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int SYNC_STAGES  = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_rx_serial,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_rx_valid,
  input  logic                 i_rx_ready,
  output logic                 o_overrun,
  output logic                 o_busy
);

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int IW   = $clog2(DATA_BITS);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int WW   = DATA_BITS + 2;

  localparam logic [CW-1:0] HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0] SAMP_A    = CW'(CLKS_PER_BIT - 3);
  localparam logic [CW-1:0] SAMP_B    = CW'(CLKS_PER_BIT - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [IW-1:0]        idx_q;
  logic                 stop_q;
  logic                 samp_a_q;
  logic                 samp_b_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 par_err_q;
  logic                 frm_err_q;
  logic                 armed_q;

  logic          bit_done;
  logic          bit_now;
  logic          push;
  logic [WW-1:0] push_word;

  logic [WW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0]   count_q;
  logic          pop;
  logic          push_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_rx_serial};
    end
  end

  assign rxs      = sync_q[SYNC_STAGES-1];
  assign bit_done = (cnt_q == BIT_LAST);
  // Third vote is the live sample taken at the decision count itself.
  assign bit_now  = (samp_a_q & samp_b_q) | (samp_a_q & rxs) | (samp_b_q & rxs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      stop_q    <= 1'b0;
      samp_a_q  <= 1'b1;
      samp_b_q  <= 1'b1;
      data_q    <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      if (state_q == S_DATA || state_q == S_PARITY || state_q == S_STOP) begin
        if (cnt_q == SAMP_A) samp_a_q <= rxs;
        if (cnt_q == SAMP_B) samp_b_q <= rxs;
        cnt_q <= bit_done ? '0 : cnt_q + 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (rxs) armed_q <= 1'b1;
          if (armed_q && !rxs) begin
            cnt_q     <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            state_q   <= S_START;
          end
        end
        S_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q <= '0;
            idx_q <= '0;
            state_q <= rxs ? S_IDLE : S_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            data_q[idx_q] <= bit_now;
            stop_q        <= 1'b0;
            if (idx_q == IDX_LAST) begin
              state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            par_err_q <= ((^data_q) ^ bit_now) != (PARITY == 1);
            state_q   <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (!bit_now) frm_err_q <= 1'b1;
            if (stop_q == STOP_LAST) begin
              state_q <= S_IDLE;
              // A low final stop bit disarms so a held break is not re-read.
              if (!bit_now) armed_q <= 1'b0;
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign push      = (state_q == S_STOP) && bit_done && (stop_q == STOP_LAST) && !rst;
  assign push_word = {frm_err_q | ~bit_now, par_err_q, data_q};

  assign o_rx_valid = (count_q != '0);
  assign pop        = o_rx_valid && i_rx_ready;
  assign push_ok    = push && ((count_q < DEPTH) || pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      count_q <= count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
    end
  end

  assign o_rx_data    = o_rx_valid ? mem_q[rd_q][DATA_BITS-1:0] : '0;
  assign o_parity_err = o_rx_valid & mem_q[rd_q][DATA_BITS];
  assign o_frame_err  = o_rx_valid & mem_q[rd_q][DATA_BITS+1];
  assign o_overrun    = push && !push_ok;
  assign o_busy       = (state_q != S_IDLE);

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver with input synchroniser, 3-sample majority vote, configurable frame format, per-word error flags, and a small receive FIFO with a valid/ready output. It sits between the board RX pin and the core-side consumer (MMIO or loader logic). It replaces the fixed 8N1, single-register receiver, which loses bytes whenever the consumer stalls.

## Interface
- CLKS_PER_BIT, 434: clocks per bit. Must be ≥ 8.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- SYNC_STAGES, 2: synchroniser flops on i_rx_serial, ≥ 2.
- FIFO_DEPTH, 4: entries, power of two, ≥ 2.
- clk  in  1  clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- i_rx_serial  in  1  asynchronous serial line; idles high.
- o_rx_data  out  DATA_BITS  head-of-FIFO data.
- o_parity_err  out  1  head word failed the parity check. Always 0 when PARITY=0.
- o_frame_err  out  1  head word had a low stop bit.
- o_rx_valid  out  1  FIFO not empty.
- i_rx_ready  in  1  consumer accepts the head word.
- o_overrun  out  1  one-cycle pulse when a completed word is dropped.
- o_busy  out  1  FSM is not in IDLE.

## Operation
- Synchroniser: chain of SYNC_STAGES flops. All stages reset to 1. Its output is `rxs`. Logic uses only `rxs`.
- Constants: HALF = CLKS_PER_BIT/2 (integer). Bit counter width is $clog2(CLKS_PER_BIT).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - An `armed` flag sets when rxs=1.
  - When `armed` and rxs=0: clear the counter, go to START.
- START:
  - Count 0..HALF-1.
  - At count HALF-1, if rxs=0: go to DATA with counter=0 and bit index=0.
  - Otherwise this is a false start: return to IDLE. Nothing is pushed.
- DATA / PARITY / STOP sampling:
  - Each bit uses counter values 0..CLKS_PER_BIT-1.
  - Record rxs at counts CLKS_PER_BIT-3, -2 and -1.
  - At count CLKS_PER_BIT-1 the bit value is the majority of the three samples. The counter then resets to 0.
- DATA:
  - Bits are received LSB first into data[idx].
  - After bit DATA_BITS-1, go to PARITY if PARITY≠0, else go to STOP.
- PARITY:
  - parity_err = (^data ^ bit) ≠ (PARITY==1). That is, odd parity requires an odd total count of ones.
- STOP:
  - frame_err is set if any of the STOP_BITS stop bits samples as 0.
  - At the decision point of the last stop bit: push {frame_err, parity_err, data} and go to IDLE.
  - `armed` clears if the last stop bit sampled 0, so a break condition does not retrigger reception.
- FIFO:
  - First-word fall-through. o_rx_data and the error flags show the head entry whenever o_rx_valid=1.
  - Pop when o_rx_valid && i_rx_ready.
  - Push is accepted if count<FIFO_DEPTH, or if a pop happens in the same cycle.
  - Otherwise the word is dropped, o_overrun=1 for that cycle, and the FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- Reset, including mid-frame:
  - FSM goes to IDLE and the partial frame is discarded.
  - FIFO is emptied. `armed`=0. Synchroniser is set to 1.
  - All outputs are 0: o_rx_data, o_parity_err, o_frame_err, o_rx_valid, o_overrun, o_busy.

## Timing
- Let t0 be the first cycle with rxs=0 in IDLE while `armed`.
- Start bit is verified at t0+HALF.
- Data bit k is decided at t0+HALF+(k+1)·CLKS_PER_BIT.
- Parity and stop bits follow at successive CLKS_PER_BIT intervals.
- The last stop bit is decided at t0+HALF+N·CLKS_PER_BIT, where N = DATA_BITS + (PARITY≠0) + STOP_BITS.
- o_rx_valid rises the cycle after that push, if the FIFO was empty.
- The FSM is in IDLE the cycle after the push, so a start edge arriving half a bit later is caught.
- o_busy=1 from t0+1 through the push cycle.
- Pop takes effect on the clock edge. The next head is visible the following cycle.
- Push and pop in the same cycle leave the count unchanged.

## Test plan
- **8N1, 0xA5, ready held high** (CLKS_PER_BIT=16): exactly one o_rx_valid pulse with data 0xA5 and both error flags 0. o_rx_valid rises 1 cycle after t0+8+9·16.
- **False start** (0-pulse of 5 clocks at CLKS_PER_BIT=16): no push and o_busy falls back to 0. A following valid 0x3C is received correctly.
- **Majority vote**: a 1-clock glitch at count CLKS_PER_BIT-2 inside a data bit leaves the bit value unchanged.
- **Parity and framing errors**:
  - PARITY=2 with 0x07 and parity bit 0: o_parity_err=1 on the head word.
  - A stop bit forced 0: o_frame_err=1.
  - A line held low afterwards produces no further frames until it returns high.
- **Overrun**: FIFO_DEPTH=4 with i_rx_ready=0 and 5 frames 0x01..0x05 sent.
  - o_overrun pulses once, on the 5th frame.
  - Draining then yields 0x01..0x04.
  - Repeat with ready asserted in the 5th-push cycle: no overrun, and 0x05 is retained.
- **Reset mid-frame**: rst asserted during data bit 3.
  - All outputs are 0 and the FIFO is empty.
  - A subsequent 0x5A is received cleanly.
